// File: rtl/rle_pkg.sv
// Shared definitions for the run-length record packer: default sizes,
// run FSM state encoding and the record width helper.
package rle_pkg;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } run_state_t;

  // A record is {bit value, run length}.
  function automatic int rec_width(input int len_w);
    return len_w + 1;
  endfunction

endpackage

// File: rtl/rle_run_packer_if.sv
// Record stream from the run packer to its consumer (valid/ready handshake).
interface rle_run_packer_if
  import rle_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) ();

  logic             out_valid;
  logic             out_ready;
  logic             out_val;
  logic [LEN_W-1:0] out_len;

  modport master (
    output out_valid,
    output out_val,
    output out_len,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_val,
    input  out_len,
    output out_ready
  );

endinterface

// File: rtl/rle_fifo.sv
// Synchronous FIFO for run records. A push while full is accepted only when
// a pop happens in the same cycle; the head is read straight from storage.
module rle_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rle_run_packer.sv
// Closes runs of identical bits into {bit, length} records and queues them
// for a valid/ready consumer. Optional drop counter: RLE_DROP_CNT_EN.
module rle_run_packer
  import rle_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic rep_bit,
  input  logic flush,
  rle_run_packer_if.master out_if,
  output logic overflow
`ifdef RLE_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int               REC_W   = rec_width(LEN_W);
  localparam logic [LEN_W-1:0] MAX_LEN = '1;
  localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

  run_state_t       state;
  run_state_t       next_state;
  logic             cur_bit;
  logic             next_cur_bit;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] next_run_len;
  logic             emit;
  logic [REC_W-1:0] emit_rec;
  logic [REC_W-1:0] head_rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      cur_bit <= 1'b0;
      run_len <= '0;
    end else begin
      state   <= next_state;
      cur_bit <= next_cur_bit;
      run_len <= next_run_len;
    end
  end

  // rep_bit is trusted as-is; it only matters while a run is open.
  always_comb begin
    next_state   = state;
    next_cur_bit = cur_bit;
    next_run_len = run_len;
    emit         = 1'b0;
    emit_rec     = {cur_bit, run_len};
    case (state)
      EMPTY: begin
        if (!flush) begin
          next_state   = RUN;
          next_cur_bit = in_bit;
          next_run_len = ONE_LEN;
        end
      end
      RUN: begin
        if (flush) begin
          emit         = 1'b1;
          next_state   = EMPTY;
          next_run_len = '0;
        end else if (rep_bit) begin
          if (run_len == MAX_LEN) begin
            emit         = 1'b1;
            next_run_len = ONE_LEN;
          end else begin
            next_run_len = run_len + 1'b1;
          end
        end else begin
          emit         = 1'b1;
          next_cur_bit = in_bit;
          next_run_len = ONE_LEN;
        end
      end
      default: begin
        next_state   = EMPTY;
        next_run_len = '0;
      end
    endcase
  end

  assign pop  = !fifo_empty && out_if.out_ready;
  assign drop = emit && fifo_full && !pop;

  rle_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .din   (emit_rec),
    .pop   (pop),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read as zero while nothing is buffered.
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_val   = fifo_empty ? 1'b0 : head_rec[REC_W-1];
  assign out_if.out_len   = fifo_empty ? '0 : head_rec[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef RLE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= 8'd0;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/rle_run_packer.md
# rle_run_packer

Downstream consumer of the repeated-bit Mealy detector. It takes the detector's serial input bit and its same-cycle "repeat" output, and closes each run of identical bits into a record {bit value, run length}. Records are buffered in a small FIFO and delivered over a valid/ready interface to the next stage, for example a UART or debug logger.

## Interface
Parameters:
- LEN_W, 8: run-length field width. Maximum recordable length is 2^LEN_W-1.
- DEPTH, 4: FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  single clock. All logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_bit  in  1  serial bit stream, one bit per clock, no valid. Same signal that drives the detector.
- rep_bit  in  1  detector output. 1 when in_bit equals the previous bit.
- flush  in  1  closes the open run, ignoring in_bit in that cycle.
- out_valid  out  1  record available at FIFO head.
- out_ready  in  1  consumer accepts the head record.
- out_val  out  1  bit value of the head record.
- out_len  out  LEN_W  run length of the head record, range 1..2^LEN_W-1.
- overflow  out  1  sticky. Set when a record is dropped; cleared only by rst.
- drop_cnt  out  8  dropped-record count. Present only with RLE_DROP_CNT_EN.

## Operation
- States: EMPTY (no open run) and RUN (cur_bit, run_len open). Reset enters EMPTY.
- EMPTY, flush=0:
  - Open a run: cur_bit=in_bit, run_len=1, go to RUN.
  - rep_bit is ignored.
- RUN, flush=1:
  - Emit {cur_bit, run_len} and go to EMPTY.
  - in_bit is ignored.
- RUN, rep_bit=1, run_len<MAX: run_len+=1.
- RUN, rep_bit=1, run_len==MAX: emit {cur_bit, MAX} and restart with run_len=1, same cur_bit.
- RUN, rep_bit=0: emit {cur_bit, run_len}, then cur_bit=in_bit, run_len=1.
- EMPTY, flush=1: no effect, no record.
- rep_bit is trusted and is not cross-checked against in_bit.
- FIFO behaviour:
  - Emit is a push. A pop occurs when out_valid && out_ready.
  - Full, push without pop: record dropped, overflow<=1.
  - Full, push with simultaneous pop: both succeed, count unchanged.
  - Empty, push with out_ready=1: the record is not bypassed. It appears the next cycle.
- Records leave in emission order. The head is stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid=0, out_val=0, out_len=0, overflow=0, drop_cnt=0.
  - FIFO empty, state EMPTY, run_len=0.
- Reset mid-run discards the open run and all buffered records. No record is emitted.
- Latency: a record is emitted in the cycle of its terminating input. With the FIFO empty, out_valid=1 on the next rising edge (1 cycle).
- Throughput: at most one push and one pop per cycle.
- Head outputs are registered or come straight from FIFO storage. There is no combinational path from in_bit, rep_bit or out_ready to the outputs.

## Configuration
- RLE_DROP_CNT_EN defined:
  - drop_cnt port exists and counts dropped records.
  - It saturates at 255 and resets to 0.
- RLE_DROP_CNT_EN undefined:
  - No drop_cnt port and no counter logic.
  - overflow behaves identically in both builds.

## Structure
- Shared package or header rle_pkg holds:
  - default LEN_W and DEPTH
  - EMPTY/RUN state encoding
  - record width LEN_W+1
- Sub-module rle_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push/din, pop/dout, full/empty.
  - Full-with-pop push is accepted.
- The top module holds the run FSM, the overflow flag and the optional drop counter.

## Test plan
- Basic runs:
  - Stimulus: in_bit 0,0,1,1,1,0 with rep_bit 0,1,0,1,1,0 and out_ready=1.
  - Response: record {0,2} valid in cycle 3 and {1,3} valid in cycle 6, each for one cycle.
- Saturation:
  - Stimulus: LEN_W=3, nine 1s (rep_bit=1 after the first), then a 0.
  - Response: {1,7} then {1,2}.
- Overflow:
  - Stimulus: DEPTH=4, out_ready=0, five alternating bits after the first, producing five records.
  - Response: overflow=1, drop_cnt=1 (macro build). Draining yields the first four records in order.
- Full with push and pop:
  - Stimulus: FIFO full, out_ready=1, push in the same cycle.
  - Response: no drop, overflow stays 0, occupancy stays 4.
- Flush:
  - Stimulus: bits 1,1, then flush=1.
  - Response: {1,2} the next cycle. The following bit opens a new run of length 1 even though rep_bit=1.
- Reset mid-run:
  - Stimulus: rst asserted with 2 records buffered and a run open.
  - Response: out_valid=0 the next cycle. The first post-reset record reflects only post-reset bits.
